bram_port_arbiter: RTL

Sequencer and two-requester arbiter for one single-port read-first BRAM instance (`single_readfirst_bram`). After reset, and on request, it sweeps every entry to zero. Otherwise it grants one requester per cycle with round-robin fairness, drives the BRAM port, and returns read data (old contents on writes) to the granted requester after the BRAM read latency. It sits between cache or predictor table logic and its backing BRAM.

---
 rtl/bram_port_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/bram_port_arbiter.sv
// Front end for one single-port read-first BRAM: zeroing sweep after reset/flush,
// then round-robin arbitration between two requesters with a latency-matched response path.
module bram_port_arbiter #(
    parameter int RAM_WIDTH  = 32,
    parameter int RAM_DEPTH  = 256,
    parameter int ADDR_WIDTH = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clka,
    input  logic                  rsta,

    input  logic                  flush_req,
    output logic                  busy,
    output logic                  clear_done,

    input  logic                  req0_valid,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [RAM_WIDTH-1:0]  req0_wdata,
    output logic                  req0_ready,
    output logic                  rsp0_valid,
    output logic [RAM_WIDTH-1:0]  rsp0_rdata,

    input  logic                  req1_valid,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [RAM_WIDTH-1:0]  req1_wdata,
    output logic                  req1_ready,
    output logic                  rsp1_valid,
    output logic [RAM_WIDTH-1:0]  rsp1_rdata,

    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [RAM_WIDTH-1:0]  ram_din,
    output logic                  ram_we,
    output logic                  ram_en,
    output logic                  ram_rst,
    output logic                  ram_regce,
    input  logic [RAM_WIDTH-1:0]  ram_dout
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   sweep_cnt;
    logic [ADDR_WIDTH-1:0]   sweep_cnt_nxt;
    logic                    last_grant;
    logic                    busy_q;
    logic                    clear_done_q;
    logic                    grant0;
    logic                    grant1;

    logic                    vld_p0;
    logic                    vld_p1;
    logic                    id_p0;
    logic                    id_p1;
    logic                    vld_out;
    logic                    id_out;

    assign sweep_cnt_nxt = sweep_cnt + 1'b1;

    // Round-robin: with both requesting, the one not served last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == ST_READY && !flush_req) begin
            if (req0_valid && (!req1_valid || last_grant)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state        <= ST_CLEAR;
            sweep_cnt    <= '0;
            last_grant   <= 1'b1;
            busy_q       <= 1'b1;
            clear_done_q <= (LAST_ADDR == '0);
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (sweep_cnt == LAST_ADDR) begin
                        state        <= ST_READY;
                        sweep_cnt    <= '0;
                        busy_q       <= 1'b0;
                        clear_done_q <= 1'b0;
                    end else begin
                        sweep_cnt    <= sweep_cnt_nxt;
                        clear_done_q <= (sweep_cnt_nxt == LAST_ADDR);
                    end
                end
                ST_READY: begin
                    if (flush_req) begin
                        state        <= ST_CLEAR;
                        sweep_cnt    <= '0;
                        busy_q       <= 1'b1;
                        clear_done_q <= (LAST_ADDR == '0);
                    end else if (grant0 || grant1) begin
                        last_grant <= grant1;
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign clear_done = clear_done_q;
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Idle cycles keep address/data parked on requester 0 to limit toggling.
    always_comb begin
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = sweep_cnt;
        ram_din  = '0;
        if (state == ST_READY) begin
            ram_en   = grant0 | grant1;
            ram_we   = grant1 ? req1_we : (grant0 & req0_we);
            ram_addr = grant1 ? req1_addr : req0_addr;
            ram_din  = grant1 ? req1_wdata : req0_wdata;
        end
    end

    assign ram_rst   = 1'b0;
    assign ram_regce = 1'b1;

    // Stage p0: grant captured alongside the BRAM address register.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= grant0 | grant1;
            vld_p1 <= vld_p0;
        end
    end

    // Stage p1: only used to match the BRAM output register.
    always_ff @(posedge clka) begin
        id_p0 <= grant1;
        id_p1 <= id_p0;
    end

    assign vld_out = (RD_LATENCY == 2) ? vld_p1 : vld_p0;
    assign id_out  = (RD_LATENCY == 2) ? id_p1  : id_p0;

    assign rsp0_valid = vld_out & ~id_out;
    assign rsp1_valid = vld_out &  id_out;
    assign rsp0_rdata = ram_dout;
    assign rsp1_rdata = ram_dout;

endmodule
